// File: rtl/imem_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : imem_arbiter_pkg
//  Description : Shared types and constants for the instruction-memory port
//                arbiter: state encoding, FIFO tag layout, the arbiter's
//                register bundle with its reset value, and the grant helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package imem_arbiter_pkg;

    // Arbiter state encoding
    typedef enum logic {
        IDLE        = 1'b0,
        REQ_PENDING = 1'b1
    } imem_arb_state_e;

    // Requester identifiers
    localparam logic c_ID_F = 1'b0;
    localparam logic c_ID_P = 1'b1;

    // One entry of the in-order ownership FIFO
    typedef struct packed {
        logic id;
        logic discard;
    } imem_arb_tag_t;

    // Control registers of the arbiter (address latch is kept separately
    // because its width is a module parameter)
    typedef struct packed {
        imem_arb_state_e state;
        logic            id;
        logic            pend_flush;
        logic            err_unexpected;
    } imem_arb_regs_t;

    localparam imem_arb_regs_t c_REGS_RESET = '{
        state:          IDLE,
        id:             c_ID_F,
        pend_flush:     1'b0,
        err_unexpected: 1'b0
    };

    // Returns the winning requester id. P wins when F is idle, or when both
    // request and the caller asks for P to be preferred.
    function automatic logic pick_winner(input logic f_valid,
                                         input logic p_valid,
                                         input logic prefer_p);
        return (~f_valid) | (p_valid & prefer_p);
    endfunction

endpackage : imem_arbiter_pkg
`default_nettype wire

// File: rtl/imem_arb_tagfifo.sv
`default_nettype none
// ============================================================================
//  Module      : imem_arb_tagfifo
//  Description : In-order FIFO of request owner tags. A flush marks every
//                held entry (and one being written in the same cycle) as
//                discard. The head is presented combinationally so a pop in
//                the flush cycle still sees its pre-flush discard bit.
//  Revision    : 1.0 - initial release
// ============================================================================
module imem_arb_tagfifo
    import imem_arbiter_pkg::*;
#(
    parameter int LOG2_DEPTH = 2
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_push,
    input  imem_arb_tag_t i_push_tag,
    input  logic          i_pop,
    input  logic          i_flush,
    output imem_arb_tag_t o_head,
    output logic          o_empty,
    output logic          o_full
);

    localparam int c_DEPTH = 1 << LOG2_DEPTH;

    logic [LOG2_DEPTH:0]   r_wr_ptr;
    logic [LOG2_DEPTH:0]   r_rd_ptr;
    logic [c_DEPTH-1:0]    r_id;
    logic [c_DEPTH-1:0]    r_discard;

    logic [LOG2_DEPTH-1:0] w_wr_idx;
    logic [LOG2_DEPTH-1:0] w_rd_idx;

    assign w_wr_idx = r_wr_ptr[LOG2_DEPTH-1:0];
    assign w_rd_idx = r_rd_ptr[LOG2_DEPTH-1:0];

    // Extra pointer MSB distinguishes full from empty when indices match
    assign o_empty = (r_wr_ptr == r_rd_ptr);
    assign o_full  = (r_wr_ptr[LOG2_DEPTH] != r_rd_ptr[LOG2_DEPTH]) &&
                     (w_wr_idx == w_rd_idx);

    assign o_head.id      = r_id[w_rd_idx];
    assign o_head.discard = r_discard[w_rd_idx];

    // Pointer advance and entry update; flush may mark stale slots too,
    // which is harmless because a push always rewrites the discard bit
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_id      <= '0;
            r_discard <= '0;
        end else begin
            if (i_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (i_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            for (int i = 0; i < c_DEPTH; i++) begin
                if (i_push && (w_wr_idx == LOG2_DEPTH'(i))) begin
                    r_id[i]      <= i_push_tag.id;
                    r_discard[i] <= i_push_tag.discard | i_flush;
                end else if (i_flush) begin
                    r_discard[i] <= 1'b1;
                end
            end
        end
    end

endmodule : imem_arb_tagfifo
`default_nettype wire

// File: rtl/imem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : imem_port_arbiter
//  Description : Shares one instruction-memory request/response channel
//                between InstrFetch (port F) and the prefetcher (port P).
//                A granted request is held on the memory port until
//                accepted; response ownership is tracked in an in-order tag
//                FIFO and flushed responses are silently dropped.
//  Options     : IMEM_ARB_ROUND_ROBIN_EN - alternate grants under contention
//                (default: fixed priority, F over P)
//  Revision    : 1.0 - initial release
// ============================================================================
module imem_port_arbiter
    import imem_arbiter_pkg::*;
#(
    parameter int ABITS      = 64,
    parameter int LOG2_DEPTH = 2
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_flush,
    // Port F
    input  logic             i_f_req_valid,
    output logic             o_f_req_ready,
    input  logic [ABITS-1:0] i_f_req_addr,
    output logic             o_f_resp_valid,
    input  logic             i_f_resp_ready,
    output logic [ABITS-1:0] o_f_resp_addr,
    output logic [63:0]      o_f_resp_data,
    output logic             o_f_resp_load_fault,
    output logic             o_f_resp_page_fault_x,
    // Port P
    input  logic             i_p_req_valid,
    output logic             o_p_req_ready,
    input  logic [ABITS-1:0] i_p_req_addr,
    output logic             o_p_resp_valid,
    input  logic             i_p_resp_ready,
    output logic [ABITS-1:0] o_p_resp_addr,
    output logic [63:0]      o_p_resp_data,
    output logic             o_p_resp_load_fault,
    output logic             o_p_resp_page_fault_x,
    // Memory side
    output logic             o_mem_req_valid,
    input  logic             i_mem_req_ready,
    output logic [ABITS-1:0] o_mem_req_addr,
    input  logic             i_mem_resp_valid,
    output logic             o_mem_resp_ready,
    input  logic [ABITS-1:0] i_mem_resp_addr,
    input  logic [63:0]      i_mem_resp_data,
    input  logic             i_mem_resp_load_fault,
    input  logic             i_mem_resp_page_fault_x,
    output logic             o_err_unexpected
);

    imem_arb_regs_t   r_regs;
    logic [ABITS-1:0] r_addr;

    imem_arb_tag_t    w_head;
    imem_arb_tag_t    w_push_tag;
    logic             w_empty;
    logic             w_full;
    logic             w_grant;
    logic             w_winner;
    logic             w_accept;
    logic             w_pop;
    logic             w_prefer_p;

`ifdef IMEM_ARB_ROUND_ROBIN_EN
    logic             r_last_p;

    // Under contention, favour whichever port did not win last time
    assign w_prefer_p = ~r_last_p;

    // Remember the most recent winner; starts as P so F gets the first tie
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_last_p <= 1'b1;
        end else if (w_grant) begin
            r_last_p <= w_winner;
        end
    end
`else
    assign w_prefer_p = 1'b0;
`endif

    assign w_grant  = (r_regs.state == IDLE) && !w_full &&
                      (i_f_req_valid || i_p_req_valid);
    assign w_winner = pick_winner(i_f_req_valid, i_p_req_valid, w_prefer_p);
    assign w_accept = (r_regs.state == REQ_PENDING) && i_mem_req_ready;

    // A flush seen while waiting for acceptance still discards that response
    assign w_push_tag.id      = r_regs.id;
    assign w_push_tag.discard = r_regs.pend_flush;

    // Grant / hold-until-accepted state machine plus sticky error flag
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_regs <= c_REGS_RESET;
            r_addr <= '1;
        end else begin
            case (r_regs.state)
                IDLE: begin
                    if (w_grant) begin
                        r_regs.state      <= REQ_PENDING;
                        r_regs.id         <= w_winner;
                        r_regs.pend_flush <= 1'b0;
                        r_addr            <= w_winner ? i_p_req_addr : i_f_req_addr;
                    end
                end
                REQ_PENDING: begin
                    if (w_accept) begin
                        r_regs.state <= IDLE;
                    end else if (i_flush) begin
                        r_regs.pend_flush <= 1'b1;
                    end
                end
                default: begin
                    r_regs.state <= IDLE;
                end
            endcase
            if (i_mem_resp_valid && w_empty) begin
                r_regs.err_unexpected <= 1'b1;
            end
        end
    end

    assign o_mem_req_valid  = (r_regs.state == REQ_PENDING);
    assign o_mem_req_addr   = r_addr;
    assign o_f_req_ready    = w_accept && (r_regs.id == c_ID_F);
    assign o_p_req_ready    = w_accept && (r_regs.id == c_ID_P);
    assign o_err_unexpected = r_regs.err_unexpected;

    // Payload fields go to both ports; only the owner's valid qualifies them
    assign o_f_resp_addr         = i_mem_resp_addr;
    assign o_f_resp_data         = i_mem_resp_data;
    assign o_f_resp_load_fault   = i_mem_resp_load_fault;
    assign o_f_resp_page_fault_x = i_mem_resp_page_fault_x;
    assign o_p_resp_addr         = i_mem_resp_addr;
    assign o_p_resp_data         = i_mem_resp_data;
    assign o_p_resp_load_fault   = i_mem_resp_load_fault;
    assign o_p_resp_page_fault_x = i_mem_resp_page_fault_x;

    // Route the response by the FIFO head; unowned or flushed ones are sunk
    always_comb begin
        o_f_resp_valid   = 1'b0;
        o_p_resp_valid   = 1'b0;
        o_mem_resp_ready = 1'b0;
        if (w_empty) begin
            o_mem_resp_ready = i_mem_resp_valid;
        end else if (w_head.discard) begin
            o_mem_resp_ready = 1'b1;
        end else if (w_head.id == c_ID_P) begin
            o_p_resp_valid   = i_mem_resp_valid;
            o_mem_resp_ready = i_p_resp_ready;
        end else begin
            o_f_resp_valid   = i_mem_resp_valid;
            o_mem_resp_ready = i_f_resp_ready;
        end
    end

    assign w_pop = i_mem_resp_valid && o_mem_resp_ready && !w_empty;

    imem_arb_tagfifo #(
        .LOG2_DEPTH (LOG2_DEPTH)
    ) u_tagfifo (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_push     (w_accept),
        .i_push_tag (w_push_tag),
        .i_pop      (w_pop),
        .i_flush    (i_flush),
        .o_head     (w_head),
        .o_empty    (w_empty),
        .o_full     (w_full)
    );

endmodule : imem_port_arbiter
`default_nettype wire

// File: tb/tb_imem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_imem_port_arbiter
//  Description : Self-checking bench for imem_port_arbiter: directed
//                scenarios with literal expectations, then randomized
//                traffic compared every cycle against a transaction model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_imem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        f_valid, f_ready, f_resp_valid, f_resp_ready, f_lf, f_pf;
    logic [63:0] f_addr, f_resp_addr, f_resp_data;
    logic        p_valid, p_ready, p_resp_valid, p_resp_ready, p_lf, p_pf;
    logic [63:0] p_addr, p_resp_addr, p_resp_data;
    logic        mreq_valid, mreq_ready, mresp_valid, mresp_ready;
    logic [63:0] mreq_addr, mresp_addr, mresp_data;
    logic        mresp_lf, mresp_pf, err;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    imem_port_arbiter #(.ABITS(64), .LOG2_DEPTH(2)) dut (
        .i_clk(clk), .i_rst(rst), .i_flush(flush),
        .i_f_req_valid(f_valid), .o_f_req_ready(f_ready), .i_f_req_addr(f_addr),
        .o_f_resp_valid(f_resp_valid), .i_f_resp_ready(f_resp_ready),
        .o_f_resp_addr(f_resp_addr), .o_f_resp_data(f_resp_data),
        .o_f_resp_load_fault(f_lf), .o_f_resp_page_fault_x(f_pf),
        .i_p_req_valid(p_valid), .o_p_req_ready(p_ready), .i_p_req_addr(p_addr),
        .o_p_resp_valid(p_resp_valid), .i_p_resp_ready(p_resp_ready),
        .o_p_resp_addr(p_resp_addr), .o_p_resp_data(p_resp_data),
        .o_p_resp_load_fault(p_lf), .o_p_resp_page_fault_x(p_pf),
        .o_mem_req_valid(mreq_valid), .i_mem_req_ready(mreq_ready),
        .o_mem_req_addr(mreq_addr),
        .i_mem_resp_valid(mresp_valid), .o_mem_resp_ready(mresp_ready),
        .i_mem_resp_addr(mresp_addr), .i_mem_resp_data(mresp_data),
        .i_mem_resp_load_fault(mresp_lf), .i_mem_resp_page_fault_x(mresp_pf),
        .o_err_unexpected(err)
    );

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Transaction-level reference: the pending offer, the ordered list of
    // outstanding owners, and the sticky error flag.
    // ------------------------------------------------------------------
    typedef struct {bit id; bit disc;} mtag_t;
    mtag_t       m_q[$];
    bit          m_pend, m_pend_id, m_pend_fl, m_err, m_last;
    logic [63:0] m_pend_addr;

    always @(negedge clk) begin : model
        bit e_frdy, e_prdy, e_mrr, e_fv, e_pv, empty, full0, acc, pop, win;
        if (rst) begin
            m_q.delete();
            m_pend = 0; m_pend_id = 0; m_pend_fl = 0; m_err = 0; m_last = 1;
            m_pend_addr = '1;
        end else begin
            empty  = (m_q.size() == 0);
            full0  = (m_q.size() == 4);
            e_frdy = m_pend && !m_pend_id && mreq_ready;
            e_prdy = m_pend &&  m_pend_id && mreq_ready;
            e_fv = 0; e_pv = 0;
            if (empty)              e_mrr = mresp_valid;
            else if (m_q[0].disc)   e_mrr = 1;
            else if (m_q[0].id)     begin e_pv = mresp_valid; e_mrr = p_resp_ready; end
            else                    begin e_fv = mresp_valid; e_mrr = f_resp_ready; end

            check("mem_req_valid", mreq_valid, m_pend);
            if (m_pend) check("mem_req_addr", mreq_addr, m_pend_addr);
            check("f_req_ready", f_ready, e_frdy);
            check("p_req_ready", p_ready, e_prdy);
            check("mem_resp_ready", mresp_ready, e_mrr);
            check("f_resp_valid", f_resp_valid, e_fv);
            check("p_resp_valid", p_resp_valid, e_pv);
            check("err_unexpected", err, m_err);
            if (e_fv) begin
                check("f_resp_addr", f_resp_addr, mresp_addr);
                check("f_resp_data", f_resp_data, mresp_data);
                check("f_resp_faults", {f_lf, f_pf}, {mresp_lf, mresp_pf});
            end
            if (e_pv) begin
                check("p_resp_addr", p_resp_addr, mresp_addr);
                check("p_resp_data", p_resp_data, mresp_data);
                check("p_resp_faults", {p_lf, p_pf}, {mresp_lf, mresp_pf});
            end

            acc = m_pend && mreq_ready;
            pop = mresp_valid && e_mrr && !empty;
            if (mresp_valid && empty) m_err = 1;
            if (pop) void'(m_q.pop_front());
            if (flush) begin
                foreach (m_q[i]) m_q[i].disc = 1;
                if (m_pend && !acc) m_pend_fl = 1;
            end
            if (m_pend) begin
                if (acc) begin
                    m_q.push_back('{id: m_pend_id, disc: m_pend_fl | flush});
                    m_pend = 0;
                end
            end else if (!full0 && (f_valid || p_valid)) begin
`ifdef IMEM_ARB_ROUND_ROBIN_EN
                win = (f_valid && p_valid) ? ~m_last : p_valid;
`else
                win = !f_valid;
`endif
                m_last      = win;
                m_pend      = 1;
                m_pend_id   = win;
                m_pend_fl   = 0;
                m_pend_addr = win ? p_addr : f_addr;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers; every helper starts and ends at posedge + 1
    // ------------------------------------------------------------------
    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        rst = 1; step(); step(); rst = 0;
    endtask

    task automatic do_req(input bit port, input logic [63:0] a, output int cyc);
        bit seen = 0;
        cyc = 0;
        if (!port) begin f_valid = 1; f_addr = a; end
        else       begin p_valid = 1; p_addr = a; end
        for (int k = 1; k <= 40 && !seen; k++) begin
            @(negedge clk);
            if ((!port && f_ready) || (port && p_ready)) begin seen = 1; cyc = k; end
            step();
        end
        if (!port) f_valid = 0; else p_valid = 0;
        check("req_accepted_in_time", seen, 1);
    endtask

    task automatic do_resp(input logic [63:0] a, input logic [63:0] d);
        bit seen = 0;
        mresp_valid = 1; mresp_addr = a; mresp_data = d;
        for (int k = 1; k <= 40 && !seen; k++) begin
            @(negedge clk);
            if (mresp_ready) seen = 1;
            step();
        end
        mresp_valid = 0;
        check("resp_accepted_in_time", seen, 1);
    endtask

    logic [63:0] mq[$];

    initial begin
        int cyc, fk, pk, pulses;
        bit rv, f_fire, p_fire, acc_fire, r_fire;

        rst = 1; flush = 0;
        f_valid = 0; f_addr = 0; f_resp_ready = 1;
        p_valid = 0; p_addr = 0; p_resp_ready = 1;
        mreq_ready = 1; mresp_valid = 0; mresp_addr = 0; mresp_data = 0;
        mresp_lf = 0; mresp_pf = 0;
        repeat (3) @(posedge clk);
        #1 rst = 0;

        // Reset state
        @(negedge clk);
        check("rst_mem_req_valid", mreq_valid, 0);
        check("rst_mem_req_addr", mreq_addr, 64'hFFFF_FFFF_FFFF_FFFF);
        check("rst_req_readies", {f_ready, p_ready, mresp_ready}, 0);
        check("rst_err", err, 0);
        step();

        // Single F request and its response
        do_req(0, 64'h1000, cyc);
        check("f_ready_cycle", cyc, 2);
        mresp_valid = 1; mresp_addr = 64'h1000; mresp_data = 64'hDEADBEEF;
        @(negedge clk);
        check("f_resp_valid", f_resp_valid, 1);
        check("f_resp_addr", f_resp_addr, 64'h1000);
        check("f_resp_data", f_resp_data, 64'hDEADBEEF);
        check("f_resp_mem_ready", mresp_ready, 1);
        step();
        mresp_valid = 0;

        // Simultaneous F and P after reset: F first, P two cycles later
        do_reset();
        f_valid = 1; f_addr = 64'h2000; p_valid = 1; p_addr = 64'h3000;
        fk = 0; pk = 0;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (f_ready && fk == 0) fk = k;
            if (p_ready && pk == 0) pk = k;
            if (k == 2) check("first_issue_addr", mreq_addr, 64'h2000);
            step();
            if (fk != 0) f_valid = 0;
            if (pk != 0) p_valid = 0;
        end
        check("contention_f_cycle", fk, 2);
        check("contention_p_cycle", pk, 4);
        do_resp(64'h2000, 64'h1);
        do_resp(64'h3000, 64'h2);

        // Memory stalls acceptance: address held, no ready pulses
        mreq_ready = 0; f_valid = 1; f_addr = 64'h4000;
        pulses = 0;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            pulses += int'(f_ready) + int'(p_ready);
            if (k >= 2) check("stall_addr_stable", mreq_addr, 64'h4000);
            step();
        end
        check("stall_no_pulse", pulses, 0);
        mreq_ready = 1;
        do_req(0, 64'h4000, cyc);
        do_resp(64'h4000, 64'h3);

        // Four outstanding requests fill the FIFO; the fifth stalls
        for (int i = 0; i < 4; i++) do_req(0, 64'h5000 + 64'(i * 16), cyc);
        f_valid = 1; f_addr = 64'h5040;
        pulses = 0;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            pulses += int'(f_ready);
            step();
        end
        check("full_stall_no_pulse", pulses, 0);
        do_resp(64'h5000, 64'h10);
        do_req(0, 64'h5040, cyc);
        check("full_release_cycle", cyc, 2);
        for (int i = 1; i <= 4; i++) do_resp(64'h5000 + 64'(i * 16), 64'h10 + 64'(i));

        // Flush drops two outstanding responses even with F not ready
        do_req(0, 64'h6000, cyc);
        do_req(0, 64'h6010, cyc);
        f_resp_ready = 0;
        flush = 1; step(); flush = 0;
        for (int i = 0; i < 2; i++) begin
            mresp_valid = 1; mresp_addr = 64'h6000 + 64'(i * 16);
            @(negedge clk);
            check("flushed_mem_ready", mresp_ready, 1);
            check("flushed_f_valid", f_resp_valid, 0);
            step();
        end
        mresp_valid = 0;
        f_resp_ready = 1;
        do_req(0, 64'h6020, cyc);
        check("post_flush_cycle", cyc, 2);
        mresp_valid = 1; mresp_addr = 64'h6020; mresp_data = 64'h77;
        @(negedge clk);
        check("post_flush_resp_valid", f_resp_valid, 1);
        step();
        mresp_valid = 0;

        // Randomized traffic against the model
        rv = 0;
        for (int n = 0; n < 3500; n++) begin
            @(negedge clk);
            f_fire   = f_valid && f_ready;
            p_fire   = p_valid && p_ready;
            acc_fire = mreq_valid && mreq_ready;
            r_fire   = mresp_valid && mresp_ready;
            if (acc_fire) mq.push_back(mreq_addr);
            step();
            if (f_fire) f_valid = 0;
            if (p_fire) p_valid = 0;
            if (n < 3000) begin
                if (!f_valid && $urandom_range(2) == 0) begin
                    f_valid = 1; f_addr = {$urandom, $urandom};
                end
                if (!p_valid && $urandom_range(2) == 0) begin
                    p_valid = 1; p_addr = {$urandom, $urandom};
                end
                flush = ($urandom_range(39) == 0);
            end else begin
                flush = 0;
            end
            mreq_ready = ($urandom_range(3) != 0);
            if (r_fire) mresp_valid = 0;
            if (!mresp_valid && mq.size() > 0 && $urandom_range(1) == 0) begin
                mresp_valid = 1;
                mresp_addr  = mq.pop_front();
                mresp_data  = {$urandom, $urandom};
                mresp_lf    = 1'($urandom);
                mresp_pf    = 1'($urandom);
            end
            f_resp_ready = ($urandom_range(3) != 0);
            p_resp_ready = ($urandom_range(3) != 0);
        end
        check("random_drained", {f_valid, p_valid, mresp_valid, 1'(mq.size() != 0)}, 0);
        f_valid = 0; p_valid = 0; mresp_valid = 0; flush = 0;
        mreq_ready = 1; f_resp_ready = 1; p_resp_ready = 1;
        step();

        // Unexpected response with nothing outstanding
        mresp_valid = 1; mresp_addr = 64'h9000;
        @(negedge clk);
        check("unexpected_mem_ready", mresp_ready, 1);
        check("unexpected_no_valid", {f_resp_valid, p_resp_valid}, 0);
        step();
        mresp_valid = 0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("err_sticky", err, 1);
            step();
        end
        do_reset();
        @(negedge clk);
        check("err_cleared_by_reset", err, 0);
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_imem_port_arbiter
`default_nettype wire

// File: doc/imem_port_arbiter.md
Name: imem_port_arbiter

Overview:
- Shares the single instruction-memory request/response channel (icache side) between two requesters: InstrFetch (port F, requester 0) and the instruction prefetcher (port P, requester 1).
- Holds a granted request stable until the memory accepts it.
- Tracks the owner of every outstanding request in an in-order tag FIFO, routes each response back to its owner, and silently discards responses invalidated by a pipeline flush.

Parameters:
abits, 64, request/response address width (RISCV_ARCH)
log2_depth, 2, log2 of the maximum number of outstanding requests (FIFO depth 4)

Ports:
i_clk  in  1  clock
i_rst  in  1  reset (see Interface)
i_flush  in  1  pipeline flush; invalidates all outstanding requests
i_f_req_valid / o_f_req_ready  in/out  1/1  port F request handshake
i_f_req_addr  in  abits  port F request address
o_f_resp_valid / i_f_resp_ready  out/in  1/1  port F response handshake
o_f_resp_addr  out  abits  port F response address
o_f_resp_data  out  64  port F response data
o_f_resp_load_fault  out  1  port F load fault
o_f_resp_page_fault_x  out  1  port F execute page fault
i_p_req_valid, o_p_req_ready, i_p_req_addr, o_p_resp_valid, i_p_resp_ready, o_p_resp_addr, o_p_resp_data, o_p_resp_load_fault, o_p_resp_page_fault_x  -  -  port P, same widths and meaning as port F
o_mem_req_valid / i_mem_req_ready  out/in  1/1  memory request handshake
o_mem_req_addr  out  abits  memory request address
i_mem_resp_valid / o_mem_resp_ready  in/out  1/1  memory response handshake
i_mem_resp_addr  in  abits  memory response address
i_mem_resp_data  in  64  memory response data
i_mem_resp_load_fault  in  1  memory load fault
i_mem_resp_page_fault_x  in  1  memory execute page fault
o_err_unexpected  out  1  sticky: a response arrived with no outstanding request

Behaviour:
- Interface: one clock i_clk; reset i_rst is synchronous and active-high.
- Reset values: state=Idle, FIFO empty, wr/rd pointers=0, o_err_unexpected=0, all *_valid and *_ready outputs=0, o_mem_req_addr='1.
- Reset mid-operation clears everything; responses still in flight after reset set o_err_unexpected.
- State machine:
  - Idle: if the FIFO is not full and any request is valid, pick a winner.
    - Fixed priority: F beats P.
    - Latch winner id and address into registers; next state is ReqPending.
  - ReqPending: o_mem_req_valid=1 and o_mem_req_addr=latched address, held stable.
    - On i_mem_req_ready: push {id, discard=0} into the FIFO.
    - Assert the winner's o_x_req_ready for exactly that cycle (one-cycle accept pulse).
    - Return to Idle.
- Request latency: 1 cycle from request valid to o_mem_req_valid. Throughput: at most 1 request per 2 cycles.
- Requester rules: a requester holds valid and address until it sees its ready pulse. The loser waits.
- FIFO full: no grant; requests stall. Push and pop in the same cycle are legal, including when full.
- Response routing (combinational from the FIFO head):
  - Head discard=0: drive the owner's resp_valid and fields; o_mem_resp_ready = owner's resp_ready.
  - Head discard=1: o_mem_resp_ready=1; no requester output asserted.
  - Pop the FIFO on i_mem_resp_valid & o_mem_resp_ready.
- FIFO empty with i_mem_resp_valid: o_mem_resp_ready=1, the response is dropped, and o_err_unexpected sets. It clears only on reset.
- i_flush:
  - Sets discard on all valid FIFO entries, including an entry pushed in the same cycle.
  - A ReqPending request is not withdrawn; it completes and its response is discarded.
  - Flush and pop in the same cycle: the popped entry is routed using its pre-flush discard value.
- Pointer arithmetic: log2_depth+1 bits, wrap naturally. Full = MSBs differ and lower bits equal.

Optional Feature:
- Macro: IMEM_ARB_ROUND_ROBIN_EN.
- Defined: a 1-bit last-winner register, reset to 1 (P). With both ports requesting, the port that did not win last is granted. A single requester always wins.
- Undefined: fixed priority, F over P; the register is not instantiated.

Decomposition:
- Shared package imem_arbiter_pkg holds:
  - state constants Idle=0, ReqPending=1
  - typedef ImemArbTag {logic id; logic discard;}
  - the ImemArbiter_registers struct and its reset constant
- Natural sub-module: imem_arb_tagfifo, a parameterized FIFO with a flush-to-discard input, instantiated once.

Test Plan:
- F requests 0x1000 with i_mem_req_ready=1; memory responds with data 0xDEADBEEF → o_f_req_ready pulses at cycle 2, and o_f_resp_valid carries addr 0x1000 and data 0xDEADBEEF.
- F (0x2000) and P (0x3000) request in the same cycle, fixed priority → 0x2000 is issued first and P's ready pulses 2 cycles later. With IMEM_ARB_ROUND_ROBIN_EN, repeated contention alternates F, P, F, P.
- i_mem_req_ready held 0 for 5 cycles → o_mem_req_addr stays stable and no requester ready pulses.
- 4 requests issued with no responses → o_f_req_ready stays 0 on the 5th request until one response pops.
- 2 outstanding F requests, then i_flush, then 2 memory responses → both consumed with o_mem_resp_ready=1 and o_f_resp_valid never asserted. A subsequent request completes normally.
- i_mem_resp_valid=1 with the FIFO empty → response accepted and o_err_unexpected=1 until i_rst.
